// File: rtl/apb4_mst_pkg.sv
// Shared types for the APB4 initiator bridge: FSM state encoding and response error codes.
package apb4_mst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_state_e;

  localparam logic [1:0] APB4_RSP_OKAY    = 2'b00;
  localparam logic [1:0] APB4_RSP_SLVERR  = 2'b01;
  localparam logic [1:0] APB4_RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/apb4_mst_bridge.sv
// APB4 initiator: converts a valid/ready request stream into single APB4 transfers and returns one
// response per request, handling wait states, PSLVERR and an optional PREADY timeout.
module apb4_mst_bridge
  import apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // A disabled timeout still needs a legal one-bit counter declaration.
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  apb4_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [2:0]              pprot_q, pprot_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              err_q, err_d;

  always_comb begin
    // NOTE: every next-state value is defaulted to its register first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    paddr_d  = paddr_q;
    pprot_d  = pprot_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          paddr_d  = req_addr_i;
          pprot_d  = req_prot_i;
          pwrite_d = req_write_i;
          pwdata_d = req_write_i ? req_wdata_i : '0;
          pstrb_d  = req_write_i ? req_wstrb_i : '0;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (TIMEOUT_EN) cnt_d = cnt_q + CNT_W'(1);
        // PREADY takes priority over a timeout expiring in the same cycle.
        if (pready_i) begin
          rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
          err_d   = pslverr_i ? APB4_RSP_SLVERR : APB4_RSP_OKAY;
          state_d = RESP;
        end else if (TIMEOUT_EN && cnt_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = APB4_RSP_TIMEOUT;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= APB4_RSP_OKAY;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pprot_q  <= pprot_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Ready is masked while reset is held so every output reads 0 during reset.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = pprot_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;

endmodule
